// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC sequencing, in-order imem requests, prefetch queue
// with valid/ready drain, and local BEQZ/BNEZ/J/JR redirect with response squashing.
module fetch_queue_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter bit                    BIT_REVERSE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  output logic                   imem_req_valid,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   inst_valid,
  output logic [INSTR_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0]  inst_pc,
  output logic [ADDR_WIDTH-1:0]  inst_pc_plus4,
  input  logic                   inst_ready,
  input  logic                   rd_valid,
  input  logic                   rd_beqz,
  input  logic                   rd_bnez,
  input  logic                   rd_jump,
  input  logic                   rd_jump_reg,
  input  logic                   rd_zero,
  input  logic [ADDR_WIDTH-1:0]  rd_pc,
  input  logic [ADDR_WIDTH-1:0]  rd_imm,
  input  logic [ADDR_WIDTH-1:0]  rd_reg
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SQ_W  = PTR_W + 3;
  localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(QUEUE_DEPTH);
  localparam logic [SQ_W-1:0]  MAX_INFLIGHT = SQ_W'(2 * QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [PTR_W-1:0]       fill_q, fill_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       unfilled_q, unfilled_d;
  logic [SQ_W-1:0]        squash_q, squash_d;
  logic [QUEUE_DEPTH-1:0] filled_q, filled_d;
  logic                   started_q;

  logic [ADDR_WIDTH-1:0]  pc_mem   [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] data_mem [QUEUE_DEPTH];

  logic                   taken;
  logic [ADDR_WIDTH-1:0]  branch_tgt;
  logic [ADDR_WIDTH-1:0]  target_raw;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   queue_full;
  logic                   accept;
  logic                   pop;
  logic                   rsp_fill;
  logic                   rsp_drop;
  logic [INSTR_WIDTH-1:0] rsp_ordered;

  // Optional bit reversal of the returned word, applied before it is stored.
  generate
    for (genvar gi = 0; gi < INSTR_WIDTH; gi++) begin : g_bits
      if (BIT_REVERSE) begin : g_rev
        assign rsp_ordered[gi] = imem_rsp_data[INSTR_WIDTH-1-gi];
      end else begin : g_fwd
        assign rsp_ordered[gi] = imem_rsp_data[gi];
      end
    end
  endgenerate

  assign taken      = rd_valid & (rd_jump | rd_jump_reg |
                                  (rd_beqz & rd_zero) | (rd_bnez & ~rd_zero));
  assign branch_tgt = rd_pc + ADDR_WIDTH'(4) + (rd_imm << 2);
  assign target_raw = rd_jump_reg ? rd_reg : branch_tgt;
  assign target     = {target_raw[ADDR_WIDTH-1:2], 2'b00};

  // Issue uses the registered occupancy, so a pop frees its slot one cycle later.
  assign queue_full     = (count_q == FULL_CNT);
  assign imem_req_valid = started_q & fetch_en & ~taken & ~queue_full;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign inst_valid    = (count_q != '0) & filled_q[head_q];
  assign inst_data     = inst_valid ? data_mem[head_q] : '0;
  assign inst_pc       = inst_valid ? pc_mem[head_q] : '0;
  assign inst_pc_plus4 = inst_pc + ADDR_WIDTH'(4);
  assign pop           = inst_valid & inst_ready;

  assign rsp_drop = imem_rsp_valid & (squash_q != '0);
  assign rsp_fill = imem_rsp_valid & (squash_q == '0) & (unfilled_q != '0) & ~taken;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    squash_d   = squash_q;
    filled_d   = filled_q;
    if (taken) begin
      // Everything still outstanding (minus this cycle's discarded response) becomes squash debt.
      fetch_pc_d = target;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      filled_d   = '0;
      squash_d   = squash_q + SQ_W'(unfilled_q) - SQ_W'(imem_rsp_valid);
    end else begin
      if (accept) begin
        fetch_pc_d       = fetch_pc_q + ADDR_WIDTH'(4);
        tail_d           = tail_q + PTR_W'(1);
        filled_d[tail_q] = 1'b0;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (rsp_fill) begin
        fill_d           = fill_q + PTR_W'(1);
        filled_d[fill_q] = 1'b1;
      end
      count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
      unfilled_d = unfilled_q + CNT_W'(accept) - CNT_W'(rsp_fill);
      squash_d   = squash_q - SQ_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC & ~ADDR_WIDTH'(3);
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      squash_q   <= '0;
      filled_q   <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      squash_q   <= squash_d;
      filled_q   <= filled_d;
      started_q  <= 1'b1;
    end
  end

  // Payload storage carries no reset; validity lives entirely in the control registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[tail_q] <= fetch_pc_q;
    end
    if (rsp_fill) begin
      data_mem[fill_q] <= rsp_ordered;
    end
  end

  a_rsp_outstanding : assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> ((squash_q != '0) || (unfilled_q != '0)));
  a_alloc_bound : assert property (@(posedge clk) disable iff (reset)
    count_q <= FULL_CNT);
  a_inflight_bound : assert property (@(posedge clk) disable iff (reset)
    (squash_q + SQ_W'(unfilled_q)) <= MAX_INFLIGHT);

endmodule
